// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode seven-segment driver for the clock/calendar digit buses.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a leading zero on pages 0 and 2.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic [1:0] page,
  input  logic [3:0] hr_10s,
  input  logic [3:0] hr_1s,
  input  logic [3:0] min_10s,
  input  logic [3:0] min_1s,
  input  logic [3:0] sec_10s,
  input  logic [3:0] sec_1s,
  input  logic [3:0] d_10s,
  input  logic [3:0] d_1s,
  input  logic [3:0] m_10s,
  input  logic [3:0] m_1s,
  input  logic [3:0] y_10s,
  input  logic [3:0] y_1s,
  input  logic [3:0] c_10s,
  input  logic [3:0] c_1s,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  // Active-low gfedcba patterns; non-BCD codes render as a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [1:0]    page_q, page_d;
  logic [15:0]   dig_q, dig_d;      // d0 in [15:12] (leftmost) .. d3 in [3:0]
  logic          sec0_q, sec0_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick_s;
  logic [15:0]   pg_dig_s;
  logic [3:0]    cur_dig_s;
  logic          blank_s;

  assign tick_s = (cnt_q == CNT_MAX);

  // Digits belonging to the live page input, captured at frame start.
  always_comb begin
    case (page)
      2'd0:    pg_dig_s = {hr_10s, hr_1s, min_10s, min_1s};
      2'd1:    pg_dig_s = {min_10s, min_1s, sec_10s, sec_1s};
      2'd2:    pg_dig_s = {d_10s, d_1s, m_10s, m_1s};
      default: pg_dig_s = {c_10s, c_1s, y_10s, y_1s};
    endcase
  end

  // Shadow digit for the slot being rendered on this tick.
  always_comb begin
    case (slot_q)
      2'd0:    cur_dig_s = dig_q[15:12];
      2'd1:    cur_dig_s = dig_q[11:8];
      2'd2:    cur_dig_s = dig_q[7:4];
      default: cur_dig_s = dig_q[3:0];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_s = (slot_q == 2'd0) && !page_q[0] && (dig_q[15:12] == 4'd0);
`else
  assign blank_s = 1'b0;
`endif

  // Next-state: refresh counter, slot scan, frame-start capture and rendered outputs.
  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    page_d = page_q;
    dig_d  = dig_q;
    sec0_d = sec0_q;
    an_d   = an_q;
    seg_d  = seg_q;
    dp_d   = dp_q;
    if (tick_s) begin
      cnt_d  = {CW{1'b0}};
      slot_d = slot_q + 2'd1;
      an_d   = ~(4'b1000 >> slot_q);
      if (blank_s) begin
        seg_d = 7'h7F;
      end else begin
        seg_d = bcd_to_seg(cur_dig_s);
      end
      // Page 2 has a fixed separator; pages 0/1 blink it with the seconds LSB.
      dp_d = ~((slot_q == 2'd1) && (page_q != 2'd3) &&
               ((page_q == 2'd2) || !sec0_q));
      if (slot_q == 2'd3) begin
        page_d = page;
        dig_d  = pg_dig_s;
        sec0_d = sec_1s[0];
      end else begin
        page_d = page_q;
        dig_d  = dig_q;
        sec0_d = sec0_q;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= {CW{1'b0}};
      slot_q <= 2'd0;
      page_q <= 2'd0;
      dig_q  <= 16'h0000;
      sec0_q <= 1'b0;
      an_q   <= 4'b1111;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      page_q <= page_d;
      dig_q  <= dig_d;
      sec0_q <= sec0_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with a frame-level reference model.
module tb_seg7_scan_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] page = 2'd0;
  logic [3:0] hr_10s = 4'd0, hr_1s = 4'd0, min_10s = 4'd0, min_1s = 4'd0;
  logic [3:0] sec_10s = 4'd0, sec_1s = 4'd0;
  logic [3:0] d_10s = 4'd0, d_1s = 4'd0, m_10s = 4'd0, m_1s = 4'd0;
  logic [3:0] y_10s = 4'd0, y_1s = 4'd0, c_10s = 4'd0, c_1s = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk_100MHz(clk), .reset_n(reset_n), .page(page),
    .hr_10s(hr_10s), .hr_1s(hr_1s), .min_10s(min_10s), .min_1s(min_1s),
    .sec_10s(sec_10s), .sec_1s(sec_1s),
    .d_10s(d_10s), .d_1s(d_1s), .m_10s(m_10s), .m_1s(m_1s),
    .y_10s(y_10s), .y_1s(y_1s), .c_10s(c_10s), .c_1s(c_1s),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: counts cycles since release, renders each slot from the frame snapshot.
  initial begin
    int cyc, slot, pg, shsec;
    int sh[4];
    exp_t e;
    cyc = 0; slot = 0; pg = 0; shsec = 0; sh = '{0, 0, 0, 0};
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        cyc = 0; slot = 0; pg = 0; shsec = 0; sh = '{0, 0, 0, 0};
      end else begin
        if (cyc % DIV == DIV - 1) begin
          e.t   = int'($time);
          e.an  = ~(4'b1000 >> slot);
          e.seg = segtab[sh[slot]];
`ifdef LEADING_ZERO_BLANK_EN
          if (slot == 0 && (pg == 0 || pg == 2) && sh[0] == 0) e.seg = 7'h7F;
`endif
          e.dp  = (slot == 1 && pg != 3 && (pg == 2 || shsec % 2 == 0)) ? 1'b0 : 1'b1;
          q.push_back(e);
          if (slot == 3) begin
            pg = int'(page);
            case (pg)
              0: sh = '{int'(hr_10s), int'(hr_1s), int'(min_10s), int'(min_1s)};
              1: sh = '{int'(min_10s), int'(min_1s), int'(sec_10s), int'(sec_1s)};
              2: sh = '{int'(d_10s), int'(d_1s), int'(m_10s), int'(m_1s)};
              default: sh = '{int'(c_10s), int'(c_1s), int'(y_10s), int'(y_1s)};
            endcase
            shsec = int'(sec_1s);
          end
          slot = (slot + 1) % 4;
        end
        cyc++;
      end
    end
  end

  // Monitor: an anode change marks a new slot; pop and compare, else outputs must hold.
  initial begin
    logic [3:0] prev_an;
    exp_t cur;
    prev_an = 4'hF;
    cur.t = 0; cur.an = 4'hF; cur.seg = 7'h7F; cur.dp = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_an = 4'hF;
        cur.an = 4'hF; cur.seg = 7'h7F; cur.dp = 1'b1;
      end else if (an !== prev_an) begin
        if (q.size() == 0) begin
          check("spurious_an", {28'd0, an}, {28'd0, prev_an});
        end else begin
          cur = q.pop_front();
          check("update_time", int'($time), cur.t + 5);
          check("an", {28'd0, an}, {28'd0, cur.an});
          check("seg", {25'd0, seg}, {25'd0, cur.seg});
          check("dp", {31'd0, dp}, {31'd0, cur.dp});
        end
        prev_an = an;
      end else begin
        check("hold_seg", {25'd0, seg}, {25'd0, cur.seg});
        check("hold_dp", {31'd0, dp}, {31'd0, cur.dp});
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_time(input int h10, h1, m10, m1, s10, s1);
    hr_10s = 4'(h10); hr_1s = 4'(h1); min_10s = 4'(m10);
    min_1s = 4'(m1); sec_10s = 4'(s10); sec_1s = 4'(s1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed scenarios followed by randomized inputs and page switches.
  initial begin
    run(3);
    reset_n = 1'b1;
    run(2);
    check("reset_an", {28'd0, an}, 32'h0000000F);

    page = 2'd0;
    set_time(1, 2, 3, 4, 5, 6);
    run(12 * DIV);

    run(6);
    reset_n = 1'b0;
    #1;
    check("async_rst_an", {28'd0, an}, 32'h0000000F);
    check("async_rst_seg", {25'd0, seg}, 32'h0000007F);
    check("async_rst_dp", {31'd0, dp}, 32'h00000001);
    run(2);
    reset_n = 1'b1;
    run(12 * DIV);

    page = 2'd1;
    sec_1s = 4'd7;
    run(9 * DIV + 2);
    sec_1s = 4'd8;
    run(12 * DIV);

    page = 2'd3;
    c_10s = 4'd2; c_1s = 4'd0; y_10s = 4'd2; y_1s = 4'd5;
    run(8 * DIV);

    page = 2'd0;
    d_10s = 4'd1; d_1s = 4'd7; m_10s = 4'd0; m_1s = 4'd9;
    run(8 * DIV);
    for (int k = 0; k < 6 * DIV && an !== 4'b1011; k++) run(1);
    check("wait_slot1", {28'd0, an}, 32'h0000000B);
    page = 2'd2;
    run(12 * DIV);

    d_10s = 4'hC;
    run(8 * DIV);

    page = 2'd0;
    hr_10s = 4'd0;
    run(8 * DIV);

    repeat (300) begin
      set_time($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      d_10s = 4'($urandom_range(0, 15)); d_1s = 4'($urandom_range(0, 15));
      m_10s = 4'($urandom_range(0, 15)); m_1s = 4'($urandom_range(0, 15));
      y_10s = 4'($urandom_range(0, 15)); y_1s = 4'($urandom_range(0, 15));
      c_10s = 4'($urandom_range(0, 15)); c_1s = 4'($urandom_range(0, 15));
      page  = 2'($urandom_range(0, 3));
      run($urandom_range(1, 12));
    end

    run(2 * DIV);
    check("queue_drain", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
